// File: rtl/adsr_pulse_scheduler_if.sv
// Control/snoop bundle between the ADSR pulse scheduler and its surroundings.
//   master : drives BPM/amplitude requests, user enable and the snooped pixel
//            handshake; observes the filter control outputs.
//   slave  : the scheduler itself.
// Ports carried: bpm_in, bpm_valid, amp_in, enable_req, pix_valid, pix_ready
// (toward the scheduler) and filter_enable, bpm_cfg, amp_cfg, frame_start,
// beat_tick, beat_count, state_dbg (from the scheduler).
interface adsr_pulse_scheduler_if #(
    parameter int MAX_BPM = 200,
    parameter int BITS    = 8
);
    localparam int BPM_W = $clog2(MAX_BPM + 1);

    logic [BPM_W-1:0] bpm_in;
    logic             bpm_valid;
    logic [BITS-1:0]  amp_in;
    logic             enable_req;
    logic             pix_valid;
    logic             pix_ready;

    logic             filter_enable;
    logic [BPM_W-1:0] bpm_cfg;
    logic [BITS-1:0]  amp_cfg;
    logic             frame_start;
    logic             beat_tick;
    logic [15:0]      beat_count;
    logic [1:0]       state_dbg;

    modport master (
        output bpm_in, bpm_valid, amp_in, enable_req, pix_valid, pix_ready,
        input  filter_enable, bpm_cfg, amp_cfg, frame_start, beat_tick,
               beat_count, state_dbg
    );

    modport slave (
        input  bpm_in, bpm_valid, amp_in, enable_req, pix_valid, pix_ready,
        output filter_enable, bpm_cfg, amp_cfg, frame_start, beat_tick,
               beat_count, state_dbg
    );
endinterface

// File: rtl/adsr_pulse_scheduler.sv
// Frame-synchronous sequencer for the ADSR brightness filter.
// Counts accepted pixels to find frame boundaries, turns the latched BPM into
// beat events with a ms-rate phase accumulator, and holds filter_enable high
// for PULSE_FRAMES whole frames per beat. BPM and amplitude reach the filter
// only at frame boundaries.
// Ports:
//   clk, reset (async, active-high)
//   bus (slave): request/snoop inputs and registered filter control outputs.
module adsr_pulse_scheduler #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int MIN_BPM      = 40,
    parameter int MAX_BPM      = 200,
    parameter int BITS         = 8,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int PULSE_FRAMES = 4
) (
    input logic                   clk,
    input logic                   reset,
    adsr_pulse_scheduler_if.slave bus
);
    localparam int BPM_W = $clog2(MAX_BPM + 1);
    localparam int PRE_N = CLK_HZ / 1000;
    localparam int PRE_W = (PRE_N > 1) ? $clog2(PRE_N) : 1;
    localparam int XW    = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int YW    = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int FW    = $clog2(PULSE_FRAMES + 1);

    typedef enum logic [1:0] {DISABLED = 2'd0, WAIT_BEAT = 2'd1, PULSE = 2'd2} state_t;

    state_t           state;
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic [PRE_W-1:0] pre;
    logic [15:0]      acc;
    logic [FW-1:0]    frames_left;
    logic             beat_pending;
    logic [BPM_W-1:0] shadow_bpm, bpm_cfg, bpm_clamped;
    logic [BITS-1:0]  shadow_amp, amp_cfg;
    logic             frame_start, beat_tick, filter_enable;
    logic [15:0]      beat_count;
    logic [16:0]      sum;
    logic             accept, frame_end, pre_tc, beat_now;

    assign accept    = bus.pix_valid & bus.pix_ready;
    // The last pixel's handshake edge is where every frame-boundary update
    // lands, so frame_start and the new config/enable appear together.
    assign frame_end = accept & (x == XW'(IMAGE_WIDTH - 1)) & (y == YW'(IMAGE_HEIGHT - 1));
    assign pre_tc    = (pre == PRE_W'(PRE_N - 1));
    assign sum       = {1'b0, acc} + 17'(bpm_cfg);
    assign beat_now  = (state != DISABLED) & pre_tc & (sum >= 17'd60000);

    always_comb begin
        bpm_clamped = bus.bpm_in;
        if (bus.bpm_in < BPM_W'(MIN_BPM))
            bpm_clamped = BPM_W'(MIN_BPM);
        else if (bus.bpm_in > BPM_W'(MAX_BPM))
            bpm_clamped = BPM_W'(MAX_BPM);
    end

    // Pixel position, shadow registers and frame-gated config.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            shadow_bpm  <= BPM_W'(MIN_BPM);
            shadow_amp  <= '0;
            bpm_cfg     <= BPM_W'(MIN_BPM);
            amp_cfg     <= '0;
        end else begin
            frame_start <= frame_end;
            shadow_amp  <= bus.amp_in;
            if (bus.bpm_valid)
                shadow_bpm <= bpm_clamped;
            if (accept) begin
                if (x == XW'(IMAGE_WIDTH - 1)) begin
                    x <= '0;
                    y <= (y == YW'(IMAGE_HEIGHT - 1)) ? '0 : y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end
            if (frame_end) begin
                bpm_cfg <= shadow_bpm;
                amp_cfg <= shadow_amp;
            end
        end
    end

    // ms prescaler and beat phase accumulator (one full beat = 60000 bpm*ms).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre        <= '0;
            acc        <= '0;
            beat_tick  <= 1'b0;
            beat_count <= '0;
        end else begin
            beat_tick  <= beat_now;
            beat_count <= beat_count + 16'(beat_now);
            if (state == DISABLED) begin
                pre <= '0;
                acc <= '0;
            end else if (pre_tc) begin
                pre <= '0;
                acc <= beat_now ? 16'(sum - 17'd60000) : sum[15:0];
            end else begin
                pre <= pre + PRE_W'(1);
            end
        end
    end

    // Sequencer. A beat landing in the consuming cycle survives as the new
    // pending beat; otherwise pending is a sticky single flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= DISABLED;
            frames_left   <= '0;
            beat_pending  <= 1'b0;
            filter_enable <= 1'b0;
        end else begin
            if (beat_now)
                beat_pending <= 1'b1;
            if (frame_end) begin
                case (state)
                    DISABLED: begin
                        if (bus.enable_req)
                            state <= WAIT_BEAT;
                    end
                    WAIT_BEAT: begin
                        if (!bus.enable_req) begin
                            state        <= DISABLED;
                            beat_pending <= 1'b0;
                        end else if (beat_pending) begin
                            state         <= PULSE;
                            frames_left   <= FW'(PULSE_FRAMES);
                            beat_pending  <= beat_now;
                            filter_enable <= 1'b1;
                        end
                    end
                    PULSE: begin
                        if (!bus.enable_req) begin
                            state         <= DISABLED;
                            frames_left   <= '0;
                            beat_pending  <= 1'b0;
                            filter_enable <= 1'b0;
                        end else if (frames_left == FW'(1)) begin
                            if (beat_pending) begin
                                frames_left  <= FW'(PULSE_FRAMES);
                                beat_pending <= beat_now;
                            end else begin
                                frames_left   <= '0;
                                state         <= WAIT_BEAT;
                                filter_enable <= 1'b0;
                            end
                        end else begin
                            frames_left <= frames_left - FW'(1);
                        end
                    end
                    default: begin
                        state         <= DISABLED;
                        beat_pending  <= 1'b0;
                        filter_enable <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.filter_enable = filter_enable;
    assign bus.bpm_cfg       = bpm_cfg;
    assign bus.amp_cfg       = amp_cfg;
    assign bus.frame_start   = frame_start;
    assign bus.beat_tick     = beat_tick;
    assign bus.beat_count    = beat_count;
    assign bus.state_dbg     = state;
endmodule
